// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply datapath.
// Default widths, FSM encoding and a constant clog2 helper.
package mm_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int VEC_LEN_DEF = 16;

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/multiplier.sv
// Unsigned combinational multiplier, W x W -> 2W.
// Operands are widened first so the product is never truncated.
module multiplier #(
   parameter int W = 32
) (
   input  logic [W-1:0]   ain,
   input  logic [W-1:0]   bin,
   output logic [2*W-1:0] dout
);

   assign dout = {{W{1'b0}}, ain} * {{W{1'b0}}, bin};

endmodule

// File: rtl/dot_product_accumulator.sv
// Streams operand pairs through a multiplier and sums VEC_LEN products.
// The finished sum is held under valid/ready until consumed.
module dot_product_accumulator
   import mm_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int VEC_LEN = VEC_LEN_DEF,
   parameter int ACC_W   = 72
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int PROD_W = 2 * DATA_W;
   localparam int CNT_W  = clog2(VEC_LEN + 1);
   localparam logic [CNT_W-1:0] LEN_C = CNT_W'(VEC_LEN);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
   logic [PROD_W-1:0]   p_q, p_d;
   logic                p_vld_q, p_vld_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [PROD_W-1:0]   prod;
   logic                accept;

   multiplier #(
      .W (DATA_W)
   ) u_mul (
      .ain  (a_in),
      .bin  (b_in),
      .dout (prod)
   );

   assign in_ready  = (state_q == ACCUM) && (in_cnt_q < LEN_C) && !clr;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);
   assign out_data  = out_valid ? acc_q : '0;

   always_comb begin
      state_d   = state_q;
      in_cnt_d  = in_cnt_q;
      acc_cnt_d = acc_cnt_q;
      p_d       = p_q;
      p_vld_d   = 1'b0;
      acc_d     = acc_q;

      case (state_q)
         ACCUM: begin
            if (accept) begin
               p_d      = prod;
               p_vld_d  = 1'b1;
               in_cnt_d = in_cnt_q + ONE_C;
            end
            if (p_vld_q) begin
               acc_d     = acc_q + ACC_W'(p_q);
               acc_cnt_d = acc_cnt_q + ONE_C;
               if (acc_cnt_d == LEN_C) state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               acc_d     = '0;
               in_cnt_d  = '0;
               acc_cnt_d = '0;
               state_d   = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase

      // Abort drops the partial sum, the in-flight product and any held result.
      if (clr) begin
         state_d   = ACCUM;
         in_cnt_d  = '0;
         acc_cnt_d = '0;
         p_d       = '0;
         p_vld_d   = 1'b0;
         acc_d     = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ACCUM;
         in_cnt_q  <= '0;
         acc_cnt_q <= '0;
         p_q       <= '0;
         p_vld_q   <= 1'b0;
         acc_q     <= '0;
      end else begin
         state_q   <= state_d;
         in_cnt_q  <= in_cnt_d;
         acc_cnt_q <= acc_cnt_d;
         p_q       <= p_d;
         p_vld_q   <= p_vld_d;
         acc_q     <= acc_d;
      end
   end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Bench for dot_product_accumulator: vector table plus hand sequences.
// Expected sums go to a queue and are popped when out_valid rises.
module tb_dot_product_accumulator;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        in_valid;
   logic        in_ready;
   logic [71:0] out_data;
   logic        out_valid;
   logic        out_ready;

   int errors = 0;
   int checks = 0;
   logic [71:0] sbq[$];
   logic        ov_prev = 1'b0;

   typedef struct {
      int          kind;
      bit          bubble;
      logic [71:0] exp;
   } vec_t;

   vec_t tbl[3];

   dot_product_accumulator dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .a_in      (a_in),
      .b_in      (b_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [71:0] act,
                      input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] opa(input int kind, input int i);
      case (kind)
         0: return 32'(10 * i);
         1: return 32'hFFFF_FFFF;
         2: return 32'(i + 1);
         3: return 32'd1;
         default: return 32'd3;
      endcase
   endfunction

   function automatic logic [31:0] opb(input int kind, input int i);
      case (kind)
         0: return 32'(i + 1);
         1: return 32'hFFFF_FFFF;
         2: return 32'd2;
         3: return 32'd1;
         default: return 32'd5;
      endcase
   endfunction

   // Drive n pairs; returns just after the edge of the last accept.
   task automatic send_vec(input int kind, input int n, input bit bubble);
      int i;
      int guard;
      i = 0;
      guard = 0;
      while (i < n && guard < 1000) begin
         @(negedge clk);
         a_in = opa(kind, i);
         b_in = opb(kind, i);
         in_valid = bubble ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (in_valid && in_ready) i++;
         @(posedge clk);
         guard++;
      end
      #1 in_valid = 1'b0;
      if (i != n) begin
         checks++;
         errors++;
         $display("FAIL send_vec: accepted %0d required %0d", i, n);
      end
   endtask

   task automatic wait_valid(input int limit);
      int g;
      g = 0;
      while (!out_valid && g < limit) begin
         @(negedge clk);
         g++;
      end
      chk("wait_valid", 72'(out_valid), 72'd1);
   endtask

   always @(negedge clk) begin
      if (out_valid === 1'b1 && !ov_prev) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got %0h required none", out_data);
         end else begin
            chk("sb_result", out_data, sbq.pop_front());
         end
      end
      ov_prev = (out_valid === 1'b1);
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{kind: 0, bubble: 1'b0, exp: 72'd13600};
      tbl[1] = '{kind: 1, bubble: 1'b0,
                 exp: (72'd1 << 68) - (72'd1 << 37) + 72'd16};
      tbl[2] = '{kind: 2, bubble: 1'b1, exp: 72'd272};

      rst = 1'b1;
      clr = 1'b0;
      a_in = '0;
      b_in = '0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 72'(in_ready), 72'd1);
      chk("rst_out_valid", 72'(out_valid), 72'd0);
      chk("rst_out_data", out_data, 72'd0);

      for (int v = 0; v < 3; v++) begin
         out_ready = 1'b1;
         send_vec(tbl[v].kind, 16, tbl[v].bubble);
         sbq.push_back(tbl[v].exp);
         @(negedge clk);
         chk("lat_low", 72'(out_valid), 72'd0);
         chk("lat_data0", out_data, 72'd0);
         @(negedge clk);
         chk("lat_high", 72'(out_valid), 72'd1);
         @(negedge clk);
         chk("pulse_end", 72'(out_valid), 72'd0);
         chk("ready_back", 72'(in_ready), 72'd1);
      end

      // Backpressure: result held, new pairs refused.
      out_ready = 1'b0;
      send_vec(0, 16, 1'b0);
      sbq.push_back(72'd13600);
      wait_valid(10);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         a_in = 32'd99;
         b_in = 32'd99;
         in_valid = 1'b1;
         #1;
         chk("hold_ready", 72'(in_ready), 72'd0);
         chk("hold_valid", 72'(out_valid), 72'd1);
         chk("hold_data", out_data, 72'd13600);
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("hold_release", 72'(out_valid), 72'd0);
      send_vec(3, 16, 1'b0);
      sbq.push_back(72'd16);
      wait_valid(10);
      @(negedge clk);

      // Reset mid-vector.
      send_vec(0, 7, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_ready", 72'(in_ready), 72'd1);
      chk("mid_rst_valid", 72'(out_valid), 72'd0);
      send_vec(3, 16, 1'b0);
      sbq.push_back(72'd16);
      wait_valid(10);
      @(negedge clk);

      // clr on the 7th pair: that pair is refused.
      send_vec(0, 6, 1'b0);
      @(negedge clk);
      a_in = 32'd1000;
      b_in = 32'd1000;
      in_valid = 1'b1;
      clr = 1'b1;
      #1;
      chk("clr_ready", 72'(in_ready), 72'd0);
      @(negedge clk);
      clr = 1'b0;
      in_valid = 1'b0;
      chk("clr_valid", 72'(out_valid), 72'd0);
      send_vec(3, 16, 1'b0);
      sbq.push_back(72'd16);
      wait_valid(10);
      @(negedge clk);

      // clr together with the output handshake.
      out_ready = 1'b0;
      send_vec(0, 16, 1'b0);
      sbq.push_back(72'd13600);
      wait_valid(10);
      @(negedge clk);
      clr = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_hs_valid", 72'(out_valid), 72'd0);
      chk("clr_hs_data", out_data, 72'd0);
      send_vec(4, 16, 1'b0);
      sbq.push_back(72'd240);
      wait_valid(10);
      @(negedge clk);
      @(negedge clk);
      chk("sb_drained", 72'(sbq.size()), 72'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
